// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parking_pkg
// Brief    : Shared state encoding, default PIN and width helper for the
//            parking-lot entry controller.
// Revision : 1.0 - initial release
// ============================================================================
package parking_pkg;

    localparam logic [4:0] ST_IDLE     = 5'b00001;
    localparam logic [4:0] ST_WAIT_PIN = 5'b00010;
    localparam logic [4:0] ST_OPEN     = 5'b00100;
    localparam logic [4:0] ST_ALARM    = 5'b01000;
    localparam logic [4:0] ST_BLOCK    = 5'b10000;

    typedef enum logic [4:0] {
        S_IDLE     = ST_IDLE,
        S_WAIT_PIN = ST_WAIT_PIN,
        S_OPEN     = ST_OPEN,
        S_ALARM    = ST_ALARM,
        S_BLOCK    = ST_BLOCK
    } state_e;

    localparam logic [7:0] DEFAULT_PIN = 8'h26;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parking_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_ctrl_if
// Brief    : Lane sensor / keypad inputs and gate / alarm outputs bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface parking_gate_ctrl_if
    import parking_pkg::*;
#(
    parameter int PIN_W     = 8,
    parameter int MAX_TRIES = 3,
    parameter int CAPACITY  = 16
) ();

    logic                           sensor_a;
    logic                           sensor_b;
    logic                           pin_valid;
    logic [PIN_W-1:0]               pin;
    logic                           car_exit;

    logic                           gate_open;
    logic                           wrong_pin_alarm;
    logic                           block_alarm;
    logic                           lot_full;
    logic [cnt_w(CAPACITY)-1:0]     occupancy;
    logic [cnt_w(MAX_TRIES)-1:0]    tries_left;

    modport master (
        output sensor_a, sensor_b, pin_valid, pin, car_exit,
        input  gate_open, wrong_pin_alarm, block_alarm, lot_full,
               occupancy, tries_left
    );

    modport slave (
        input  sensor_a, sensor_b, pin_valid, pin, car_exit,
        output gate_open, wrong_pin_alarm, block_alarm, lot_full,
               occupancy, tries_left
    );

endinterface
`default_nettype wire

// File: rtl/parking_occupancy.sv
`default_nettype none
// ============================================================================
// Module   : parking_occupancy
// Brief    : Saturating up/down counter of cars in the lot with full flag.
// Revision : 1.0 - initial release
// ============================================================================
module parking_occupancy
    import parking_pkg::*;
#(
    parameter int CAPACITY = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       inc,
    input  wire logic                       dec,
    output logic [cnt_w(CAPACITY)-1:0]      occupancy,
    output logic                            full
);

    localparam int                OCC_W = cnt_w(CAPACITY);
    localparam logic [OCC_W-1:0]  CAP_V = OCC_W'(CAPACITY);

    logic [OCC_W-1:0] occ_d, occ_q;
    logic             full_d, full_q;

    always_comb begin
        occ_d = occ_q;
        // Simultaneous entry and exit cancel; both ends saturate.
        if (inc && !dec) begin
            if (occ_q != CAP_V) occ_d = occ_q + 1'b1;
        end else if (dec && !inc) begin
            if (occ_q != '0) occ_d = occ_q - 1'b1;
        end
        full_d = (occ_d == CAP_V);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            full_q <= full_d;
        end
    end

    assign occupancy = occ_q;
    assign full      = full_q;

endmodule
`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_ctrl
// Brief    : Parking-lot entry gate controller: PIN entry with attempt limit,
//            tailgate blocking, open-gate timeout and occupancy tracking.
// Revision : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int               PIN_W        = 8,
    parameter logic [PIN_W-1:0] PIN          = PIN_W'(DEFAULT_PIN),
    parameter int               MAX_TRIES    = 3,
    parameter int               CAPACITY     = 16,
    parameter int               OPEN_TIMEOUT = 100
) (
    input  wire logic           clk,
    input  wire logic           rst,
    parking_gate_ctrl_if.slave  bus
);

    localparam int               FAIL_W   = cnt_w(MAX_TRIES);
    localparam int               TMR_W    = cnt_w(OPEN_TIMEOUT);
    localparam logic [FAIL_W-1:0] MAX_V   = FAIL_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(OPEN_TIMEOUT - 1);

    state_e              state_d, state_q;
    logic [FAIL_W-1:0]   fail_d, fail_q;
    logic [TMR_W-1:0]    timer_d, timer_q;
    logic                gate_open_d, gate_open_q;
    logic                wrong_pin_alarm_d, wrong_pin_alarm_q;
    logic                block_alarm_d, block_alarm_q;
    logic [FAIL_W-1:0]   tries_left_d, tries_left_q;

    logic                w_conflict;
    logic                w_pin_ok;
    logic                w_occ_inc;
    logic                w_lot_full;
    logic [cnt_w(CAPACITY)-1:0] w_occupancy;

    assign w_conflict = bus.sensor_a && bus.sensor_b;
    assign w_pin_ok   = bus.pin_valid && (bus.pin == PIN);

    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        timer_d   = timer_q;
        w_occ_inc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_conflict) begin
                    state_d = S_BLOCK;
                end else if (bus.sensor_a && !w_lot_full) begin
                    state_d = S_WAIT_PIN;
                    fail_d  = '0;
                end
            end

            S_WAIT_PIN: begin
                if (w_conflict) begin
                    state_d = S_BLOCK;
                end else if (w_pin_ok) begin
                    state_d = S_OPEN;
                    timer_d = '0;
                end else if (bus.pin_valid) begin
                    fail_d = fail_q + 1'b1;
                    if (fail_d == MAX_V) state_d = S_ALARM;
                end else if (!bus.sensor_a) begin
                    state_d = S_IDLE;
                end
            end

            S_OPEN: begin
                // sensor_b without sensor_a is a completed entry here.
                if (w_conflict) begin
                    state_d = S_BLOCK;
                end else if (bus.sensor_b) begin
                    state_d   = S_IDLE;
                    w_occ_inc = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_ALARM: begin
                if (w_pin_ok) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end
            end

            S_BLOCK: begin
                if (w_pin_ok && !bus.sensor_b) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        gate_open_d       = (state_d == S_OPEN);
        wrong_pin_alarm_d = (state_d == S_ALARM);
        block_alarm_d     = (state_d == S_BLOCK);
        tries_left_d      = MAX_V - fail_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            fail_q            <= '0;
            timer_q           <= '0;
            gate_open_q       <= 1'b0;
            wrong_pin_alarm_q <= 1'b0;
            block_alarm_q     <= 1'b0;
            tries_left_q      <= MAX_V;
        end else begin
            state_q           <= state_d;
            fail_q            <= fail_d;
            timer_q           <= timer_d;
            gate_open_q       <= gate_open_d;
            wrong_pin_alarm_q <= wrong_pin_alarm_d;
            block_alarm_q     <= block_alarm_d;
            tries_left_q      <= tries_left_d;
        end
    end

    parking_occupancy #(
        .CAPACITY (CAPACITY)
    ) u_occupancy (
        .clk       (clk),
        .rst       (rst),
        .inc       (w_occ_inc),
        .dec       (bus.car_exit),
        .occupancy (w_occupancy),
        .full      (w_lot_full)
    );

    assign bus.gate_open       = gate_open_q;
    assign bus.wrong_pin_alarm = wrong_pin_alarm_q;
    assign bus.block_alarm     = block_alarm_q;
    assign bus.lot_full        = w_lot_full;
    assign bus.occupancy       = w_occupancy;
    assign bus.tries_left      = tries_left_q;

endmodule
`default_nettype wire
